// File: rtl/fpga_spi_pkg.sv
// Shared types and sizing for the fabric-side SPI slave.
package fpga_spi_pkg;

  typedef enum logic {
    StIdle,
    StShift
  } spi_state_e;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous input, with edge flags derived from the
// last synchronizer stage and one extra history flop.
module spi_sync_edge
  import fpga_spi_pkg::*;
#(
  parameter int unsigned Stages = SYNC_STAGES
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [Stages-1:0] sync_q;
  logic              last_q;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], din};
      last_q <= sync_q[Stages-1];
    end
  end

  // Both terms come straight from flops, so the edge flags are glitch-free.
  assign dout = sync_q[Stages-1];
  assign rise = dout & ~last_q;
  assign fall = ~dout & last_q;

endmodule

// File: rtl/fpga_spi_slave.sv
// SPI mode-0 slave oversampled on clk_sys; byte framing by csn and by an inter-bit timeout,
// since the master may keep csn low for ever.
module fpga_spi_slave
  import fpga_spi_pkg::*;
#(
  parameter int unsigned TIMEOUT = 30
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              spi_csn,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_vld,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_vld,
  output logic              tx_rdy,
  output logic              err_abort
);

  localparam logic [7:0] ToLast  = 8'(TIMEOUT - 1);
  localparam logic [2:0] BitLast = 3'(BYTE_W - 1);

  logic sck_rise, sck_fall, csn_s, mosi_s;
  logic csn_rise, csn_fall, mosi_rise, mosi_fall, sck_s;

  spi_sync_edge #(.Stages(SYNC_STAGES)) u_sync_sck (
    .clk_sys (clk_sys),
    .rst     (rst),
    .din     (spi_sck),
    .dout    (sck_s),
    .rise    (sck_rise),
    .fall    (sck_fall)
  );

  spi_sync_edge #(.Stages(SYNC_STAGES)) u_sync_csn (
    .clk_sys (clk_sys),
    .rst     (rst),
    .din     (spi_csn),
    .dout    (csn_s),
    .rise    (csn_rise),
    .fall    (csn_fall)
  );

  spi_sync_edge #(.Stages(SYNC_STAGES)) u_sync_mosi (
    .clk_sys (clk_sys),
    .rst     (rst),
    .din     (spi_mosi),
    .dout    (mosi_s),
    .rise    (mosi_rise),
    .fall    (mosi_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{sck_s, sck_fall, csn_rise, csn_fall, mosi_rise, mosi_fall};

  spi_state_e        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        to_cnt_q, to_cnt_d;
  logic [BYTE_W-2:0] shift_q, shift_d;
  logic [BYTE_W-1:0] rx_data_q, rx_data_d;
  logic              rx_vld_q, rx_vld_d;
  logic              err_abort_q, err_abort_d;
  logic [BYTE_W-1:0] tx_buf_q, tx_buf_d;
  logic              tx_full_q, tx_full_d;
  logic [BYTE_W-1:0] tx_sh_q, tx_sh_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    to_cnt_d    = to_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_vld_d    = 1'b0;
    err_abort_d = 1'b0;
    tx_buf_d    = tx_buf_q;
    tx_full_d   = tx_full_q;
    tx_sh_d     = tx_sh_q;

    if (tx_vld && !tx_full_q) begin
      tx_buf_d  = tx_data;
      tx_full_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (sck_rise && !csn_s) begin
          shift_d   = {{(BYTE_W-2){1'b0}}, mosi_s};
          bit_cnt_d = 3'd1;
          to_cnt_d  = '0;
          tx_sh_d   = {tx_sh_q[BYTE_W-2:0], 1'b0};
          state_d   = StShift;
        end else if (tx_full_q) begin
          tx_sh_d   = tx_buf_q;
          tx_full_d = 1'b0;
        end
      end
      StShift: begin
        if (csn_s) begin
          err_abort_d = 1'b1;
          shift_d     = '0;
          tx_sh_d     = '0;
          state_d     = StIdle;
        end else if (sck_rise) begin
          shift_d   = {shift_q[BYTE_W-3:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          to_cnt_d  = '0;
          tx_sh_d   = {tx_sh_q[BYTE_W-2:0], 1'b0};
          if (bit_cnt_q == BitLast) begin
            rx_data_d = {shift_q, mosi_s};
            rx_vld_d  = 1'b1;
            shift_d   = '0;
            tx_sh_d   = '0;
            state_d   = StIdle;
          end
        end else if (to_cnt_q == ToLast) begin
          err_abort_d = 1'b1;
          shift_d     = '0;
          tx_sh_d     = '0;
          state_d     = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_vld_q    <= 1'b0;
      err_abort_q <= 1'b0;
      tx_buf_q    <= '0;
      tx_full_q   <= 1'b0;
      tx_sh_q     <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_vld_q    <= rx_vld_d;
      err_abort_q <= err_abort_d;
      tx_buf_q    <= tx_buf_d;
      tx_full_q   <= tx_full_d;
      tx_sh_q     <= tx_sh_d;
    end
  end

  assign spi_miso  = tx_sh_q[BYTE_W-1] & ~csn_s;
  assign rx_data   = rx_data_q;
  assign rx_vld    = rx_vld_q;
  assign tx_rdy    = ~tx_full_q;
  assign err_abort = err_abort_q;

endmodule

// File: tb/tb_fpga_spi_slave.sv
// Directed bench: a 10 MHz SPI master model drives byte bursts and checks framing, MISO data,
// timeout/csn aborts and asynchronous reset.
module tb_fpga_spi_slave;

  logic       clk_sys = 1'b0;
  logic       rst = 1'b1;
  logic       spi_csn = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic [7:0] tx_data = 8'h00;
  logic       tx_vld = 1'b0;
  logic       tx_rdy;
  logic       err_abort;

  fpga_spi_slave #(.TIMEOUT(30)) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .spi_csn   (spi_csn),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .rx_data   (rx_data),
    .rx_vld    (rx_vld),
    .tx_data   (tx_data),
    .tx_vld    (tx_vld),
    .tx_rdy    (tx_rdy),
    .err_abort (err_abort)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int vld_cnt = 0;
  int abort_cnt = 0;
  int vld_cyc = 0;
  int abort_cyc = 0;
  always @(negedge clk_sys) begin
    if (!rst) begin
      if (rx_vld) begin
        vld_cnt <= vld_cnt + 1;
        vld_cyc <= cyc;
      end
      if (err_abort) begin
        abort_cnt <= abort_cnt + 1;
        abort_cyc <= cyc;
      end
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Sends the top n bits of b, 5 cycles low / 5 high per bit; samples MISO just before each rise.
  task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] mi,
                           output int rise_cyc);
    mi = 8'h00;
    rise_cyc = 0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      repeat (5) @(negedge clk_sys);
      mi = {mi[6:0], spi_miso};
      spi_sck = 1'b1;
      rise_cyc = cyc;
      repeat (5) @(negedge clk_sys);
      spi_sck = 1'b0;
    end
  endtask

  task automatic write_tx(input logic [7:0] d);
    tx_data = d;
    tx_vld  = 1'b1;
    @(negedge clk_sys);
    tx_vld  = 1'b0;
  endtask

  typedef struct {
    logic [7:0] mosi;
    logic       load;
    logic [7:0] tx;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
    logic       chk_period;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] mi;
  int         rc, cc, v0, a0, pv;

  initial begin
    vecs[0] = '{mosi: 8'h00, load: 1'b0, tx: 8'h00, exp_rx: 8'h00, exp_miso: 8'h00, chk_period: 1'b0};
    vecs[1] = '{mosi: 8'h00, load: 1'b0, tx: 8'h00, exp_rx: 8'h00, exp_miso: 8'h00, chk_period: 1'b1};
    vecs[2] = '{mosi: 8'hA5, load: 1'b0, tx: 8'h00, exp_rx: 8'hA5, exp_miso: 8'h00, chk_period: 1'b1};
    vecs[3] = '{mosi: 8'h3C, load: 1'b1, tx: 8'hC3, exp_rx: 8'h3C, exp_miso: 8'hC3, chk_period: 1'b0};
    vecs[4] = '{mosi: 8'h00, load: 1'b0, tx: 8'h00, exp_rx: 8'h00, exp_miso: 8'h00, chk_period: 1'b1};
    vecs[5] = '{mosi: 8'hFF, load: 1'b1, tx: 8'h81, exp_rx: 8'hFF, exp_miso: 8'h81, chk_period: 1'b0};

    repeat (3) @(negedge clk_sys);
    check("reset_miso", int'(spi_miso), 0);
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_rx_vld", int'(rx_vld), 0);
    check("reset_tx_rdy", int'(tx_rdy), 1);
    check("reset_err_abort", int'(err_abort), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk_sys);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].load) begin
        write_tx(vecs[i].tx);
        check("tx_rdy_low_after_write", int'(tx_rdy), 0);
        repeat (2) @(negedge clk_sys);
        check("tx_rdy_back_high", int'(tx_rdy), 1);
      end
      v0 = vld_cnt;
      a0 = abort_cnt;
      pv = vld_cyc;
      send_bits(vecs[i].mosi, 8, mi, rc);
      repeat (50) @(negedge clk_sys);
      check($sformatf("vec%0d_rx_data", i), int'(rx_data), int'(vecs[i].exp_rx));
      check($sformatf("vec%0d_vld_pulses", i), vld_cnt - v0, 1);
      check($sformatf("vec%0d_abort_pulses", i), abort_cnt - a0, 0);
      check($sformatf("vec%0d_miso", i), int'(mi), int'(vecs[i].exp_miso));
      check($sformatf("vec%0d_vld_latency", i), vld_cyc - rc, 3);
      if (vecs[i].chk_period) check($sformatf("vec%0d_vld_period", i), vld_cyc - pv, 130);
    end

    // SCK stalls after 5 bits: timeout abort, rx_data keeps the previous byte.
    v0 = vld_cnt;
    a0 = abort_cnt;
    send_bits(8'hB0, 5, mi, rc);
    repeat (60) @(negedge clk_sys);
    check("timeout_abort_pulses", abort_cnt - a0, 1);
    check("timeout_abort_delay", abort_cyc - rc, 33);
    check("timeout_no_vld", vld_cnt - v0, 0);
    check("timeout_rx_kept", int'(rx_data), 8'hFF);
    send_bits(8'h5A, 8, mi, rc);
    repeat (50) @(negedge clk_sys);
    check("after_timeout_rx", int'(rx_data), 8'h5A);
    check("after_timeout_vld", vld_cnt - v0, 1);

    // csn raised after 3 bits.
    write_tx(8'hFF);
    repeat (3) @(negedge clk_sys);
    v0 = vld_cnt;
    a0 = abort_cnt;
    send_bits(8'h00, 3, mi, rc);
    check("csn_miso_before", int'(spi_miso), 1);
    spi_csn = 1'b1;
    cc = cyc;
    repeat (6) @(negedge clk_sys);
    check("csn_miso_zero", int'(spi_miso), 0);
    check("csn_abort_pulses", abort_cnt - a0, 1);
    check("csn_abort_within_3", int'((abort_cyc - cc) <= 3 && (abort_cyc - cc) > 0), 1);
    repeat (10) @(negedge clk_sys);
    check("csn_miso_still_zero", int'(spi_miso), 0);
    spi_csn = 1'b0;
    repeat (50) @(negedge clk_sys);
    check("csn_no_vld", vld_cnt - v0, 0);
    check("csn_rx_kept", int'(rx_data), 8'h5A);

    // Reset in the middle of bit 4, with a pending transmit write.
    write_tx(8'hFF);
    repeat (3) @(negedge clk_sys);
    v0 = vld_cnt;
    a0 = abort_cnt;
    send_bits(8'hFF, 4, mi, rc);
    check("prerst_miso", int'(spi_miso), 1);
    write_tx(8'h77);
    check("prerst_tx_rdy", int'(tx_rdy), 0);
    rst = 1'b1;
    #1;
    check("rst_miso", int'(spi_miso), 0);
    check("rst_rx_data", int'(rx_data), 0);
    check("rst_rx_vld", int'(rx_vld), 0);
    check("rst_tx_rdy", int'(tx_rdy), 1);
    check("rst_err_abort", int'(err_abort), 0);
    repeat (3) @(negedge clk_sys);
    rst = 1'b0;
    repeat (10) @(negedge clk_sys);
    send_bits(8'h81, 8, mi, rc);
    repeat (50) @(negedge clk_sys);
    check("after_rst_rx", int'(rx_data), 8'h81);
    check("after_rst_vld", vld_cnt - v0, 1);
    check("after_rst_abort", abort_cnt - a0, 0);
    check("after_rst_miso", int'(mi), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench watchdog expired");
  end

endmodule
